fpu_writeback_queue: RTL and testbench

Write-side front end for the FPU register file. Collects results from the FPU's two result sources: a single-cycle unit (add/sub/cmp/move) and a multi-cycle unit (mul/div/sqrt). Buffers them in an in-order FIFO and drives the register file's single write port (`reg_write`, `write_reg`, `write_data`) at one write per cycle. It also keeps a per-register pending-write scoreboard, so the FPU issue stage stalls on RAW/WAW hazards against results not yet committed.

---
 rtl/fpu_writeback_queue_if.sv | 44 ++++
 rtl/fpu_writeback_queue.sv | 99 +++++++++
 tb/tb_fpu_writeback_queue.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_writeback_queue_if.sv
// Bundle between the FPU issue/result side and the register file writeback queue.
// The master modport is the FPU side; the slave modport is the queue.
interface fpu_writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) ();
    logic                       issue_valid;
    logic [4:0]                 issue_rd;
    logic [4:0]                 query_rs1;
    logic [4:0]                 query_rs2;
    logic [4:0]                 query_rs3;
    logic                       issue_stall;

    logic                       res0_valid;
    logic                       res0_ready;
    logic [4:0]                 res0_rd;
    logic [DATA_W-1:0]          res0_data;

    logic                       res1_valid;
    logic                       res1_ready;
    logic [4:0]                 res1_rd;
    logic [DATA_W-1:0]          res1_data;

    logic                       reg_write;
    logic [4:0]                 write_reg;
    logic [DATA_W-1:0]          write_data;
    logic [$clog2(DEPTH):0]     wb_count;

    modport master (
        output issue_valid, issue_rd, query_rs1, query_rs2, query_rs3,
        output res0_valid, res0_rd, res0_data,
        output res1_valid, res1_rd, res1_data,
        input  issue_stall, res0_ready, res1_ready,
        input  reg_write, write_reg, write_data, wb_count
    );

    modport slave (
        input  issue_valid, issue_rd, query_rs1, query_rs2, query_rs3,
        input  res0_valid, res0_rd, res0_data,
        input  res1_valid, res1_rd, res1_data,
        output issue_stall, res0_ready, res1_ready,
        output reg_write, write_reg, write_data, wb_count
    );
endinterface

// File: rtl/fpu_writeback_queue.sv
// In-order FIFO merging two FPU result sources into one register file write port, plus pending-write scoreboard.
// Latency: accept to reg_write strobe is 1 edge, scoreboard clear at the 2nd edge; drains one entry per cycle.
// Backpressure: readies derive from registered free space only (no same-cycle dequeue credit); res1 yields to res0.
module fpu_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    fpu_writeback_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] dat;
    } wb_entry_t;

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_pending;
    logic               r_reg_write;
    logic [4:0]         r_write_reg;
    logic [DATA_W-1:0]  r_write_data;

    logic [CNT_W-1:0]   w_free;
    logic               w_res0_rdy;
    logic               w_res1_rdy;
    logic               w_enq0;
    logic               w_enq1;
    logic               w_deq;
    logic [PTR_W-1:0]   w_wr_ptr1;
    logic [31:0]        w_pending_nxt;

    always_comb begin
        w_free     = CNT_W'(DEPTH) - r_count;
        w_res0_rdy = (w_free >= CNT_W'(1));
        // res1 must leave room for res0 whenever res0 is offering
        w_res1_rdy = bus.res0_valid ? (w_free >= CNT_W'(2)) : (w_free >= CNT_W'(1));
        w_enq0     = bus.res0_valid & w_res0_rdy;
        w_enq1     = bus.res1_valid & w_res1_rdy;
        w_deq      = (r_count != '0);
        w_wr_ptr1  = r_wr_ptr + PTR_W'(w_enq0);
    end

    // Set after clear so a same-edge issue to the committing register stays pending
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_reg_write) begin
            w_pending_nxt[r_write_reg] = 1'b0;
        end
        if (bus.issue_valid) begin
            w_pending_nxt[bus.issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq0) begin
            r_mem[r_wr_ptr] <= {bus.res0_rd, bus.res0_data};
        end
        if (w_enq1) begin
            r_mem[w_wr_ptr1] <= {bus.res1_rd, bus.res1_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_pending    <= '0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else begin
            r_wr_ptr  <= r_wr_ptr + PTR_W'(w_enq0) + PTR_W'(w_enq1);
            r_count   <= r_count + CNT_W'(w_enq0) + CNT_W'(w_enq1) - CNT_W'(w_deq);
            r_pending <= w_pending_nxt;
            r_reg_write <= w_deq;
            if (w_deq) begin
                r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
                r_write_reg  <= r_mem[r_rd_ptr].rd;
                r_write_data <= r_mem[r_rd_ptr].dat;
            end
        end
    end

    assign bus.issue_stall = r_pending[bus.query_rs1] | r_pending[bus.query_rs2] |
                             r_pending[bus.query_rs3] | r_pending[bus.issue_rd];
    assign bus.res0_ready  = w_res0_rdy;
    assign bus.res1_ready  = w_res1_rdy;
    assign bus.reg_write   = r_reg_write;
    assign bus.write_reg   = r_write_reg;
    assign bus.write_data  = r_write_data;
    assign bus.wb_count    = r_count;
endmodule

// File: tb/tb_fpu_writeback_queue.sv
// Directed bench for fpu_writeback_queue: a DEPTH=4 instance for the main flow and a DEPTH=2 instance to reach full.
module tb_fpu_writeback_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fpu_writeback_queue_if #(.DEPTH(4), .DATA_W(32)) b  ();
    fpu_writeback_queue_if #(.DEPTH(2), .DATA_W(32)) b2 ();

    fpu_writeback_queue #(.DEPTH(4), .DATA_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    fpu_writeback_queue #(.DEPTH(2), .DATA_W(32)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b.issue_valid = 1'b0;  b.issue_rd  = '0;
        b.query_rs1   = '0;    b.query_rs2 = '0;  b.query_rs3 = '0;
        b.res0_valid  = 1'b0;  b.res0_rd   = '0;  b.res0_data = '0;
        b.res1_valid  = 1'b0;  b.res1_rd   = '0;  b.res1_data = '0;
        b2.issue_valid = 1'b0; b2.issue_rd  = '0;
        b2.query_rs1   = '0;   b2.query_rs2 = '0; b2.query_rs3 = '0;
        b2.res0_valid  = 1'b0; b2.res0_rd   = '0; b2.res0_data = '0;
        b2.res1_valid  = 1'b0; b2.res1_rd   = '0; b2.res1_data = '0;
    endtask

    initial begin
        idle();
        tick(); tick();
        rst = 1'b0;

        // Random activity, then reset held two cycles
        b.issue_valid = 1'b1; b.issue_rd = 5'd3;
        b.res0_valid = 1'b1; b.res0_rd = 5'd9; b.res0_data = $urandom;
        b.res1_valid = 1'b1; b.res1_rd = 5'd4; b.res1_data = $urandom;
        tick(); tick();
        rst = 1'b1;
        idle();
        tick(); tick();
        chk("rst_reg_write", 64'(b.reg_write), 64'd0);
        chk("rst_write_reg", 64'(b.write_reg), 64'd0);
        chk("rst_write_data", 64'(b.write_data), 64'd0);
        chk("rst_wb_count", 64'(b.wb_count), 64'd0);
        chk("rst_stall", 64'(b.issue_stall), 64'd0);
        b.query_rs1 = 5'd3; #1;
        chk("rst_pending3", 64'(b.issue_stall), 64'd0);
        b.query_rs1 = 5'd0;
        rst = 1'b0;
        tick();

        // Single path
        b.issue_valid = 1'b1; b.issue_rd = 5'd5;
        tick();
        b.issue_valid = 1'b0; b.issue_rd = 5'd0; b.query_rs1 = 5'd5; #1;
        chk("sp_stall_set", 64'(b.issue_stall), 64'd1);
        b.res0_valid = 1'b1; b.res0_rd = 5'd5; b.res0_data = 32'h3F800000; #1;
        chk("sp_res0_ready", 64'(b.res0_ready), 64'd1);
        tick();
        b.res0_valid = 1'b0; #1;
        chk("sp_count1", 64'(b.wb_count), 64'd1);
        chk("sp_no_write_yet", 64'(b.reg_write), 64'd0);
        tick();
        chk("sp_reg_write", 64'(b.reg_write), 64'd1);
        chk("sp_write_reg", 64'(b.write_reg), 64'd5);
        chk("sp_write_data", 64'(b.write_data), 64'h3F800000);
        chk("sp_count0", 64'(b.wb_count), 64'd0);
        chk("sp_stall_held", 64'(b.issue_stall), 64'd1);
        tick();
        chk("sp_reg_write_low", 64'(b.reg_write), 64'd0);
        chk("sp_stall_clear", 64'(b.issue_stall), 64'd0);
        chk("sp_data_hold", 64'(b.write_data), 64'h3F800000);
        b.query_rs1 = 5'd0;

        // Dual enqueue, res0 ahead of res1
        b.res0_valid = 1'b1; b.res0_rd = 5'd1; b.res0_data = 32'h40000000;
        b.res1_valid = 1'b1; b.res1_rd = 5'd2; b.res1_data = 32'h40400000; #1;
        chk("du_res0_ready", 64'(b.res0_ready), 64'd1);
        chk("du_res1_ready", 64'(b.res1_ready), 64'd1);
        tick();
        b.res0_valid = 1'b0; b.res1_valid = 1'b0; #1;
        chk("du_count2", 64'(b.wb_count), 64'd2);
        tick();
        chk("du_w1_reg", 64'(b.write_reg), 64'd1);
        chk("du_w1_data", 64'(b.write_data), 64'h40000000);
        chk("du_count1", 64'(b.wb_count), 64'd1);
        tick();
        chk("du_w2_strobe", 64'(b.reg_write), 64'd1);
        chk("du_w2_reg", 64'(b.write_reg), 64'd2);
        chk("du_w2_data", 64'(b.write_data), 64'h40400000);
        chk("du_count0", 64'(b.wb_count), 64'd0);
        tick();
        chk("du_idle", 64'(b.reg_write), 64'd0);

        // Fill DEPTH=4 to 3 entries, then one free slot with both sources valid
        b.issue_valid = 1'b1; b.issue_rd = 5'd20;
        b.res0_valid = 1'b1; b.res0_rd = 5'd10; b.res0_data = 32'hA0;
        b.res1_valid = 1'b1; b.res1_rd = 5'd11; b.res1_data = 32'hA1;
        tick();
        b.issue_valid = 1'b0; b.issue_rd = 5'd0;
        b.res0_rd = 5'd12; b.res0_data = 32'hA2;
        b.res1_rd = 5'd13; b.res1_data = 32'hA3; #1;
        chk("fl_res1_ready_free2", 64'(b.res1_ready), 64'd1);
        tick();
        chk("fl_count3", 64'(b.wb_count), 64'd3);
        chk("fl_pop10", 64'(b.write_reg), 64'd10);
        b.res0_rd = 5'd14; b.res0_data = 32'hA4;
        b.res1_rd = 5'd15; b.res1_data = 32'hA5; #1;
        chk("fl_res0_ready_free1", 64'(b.res0_ready), 64'd1);
        chk("fl_res1_ready_free1", 64'(b.res1_ready), 64'd0);
        tick();
        b.res0_valid = 1'b0; b.res1_valid = 1'b0; #1;
        chk("fl_count_still3", 64'(b.wb_count), 64'd3);
        chk("fl_pop11", 64'(b.write_reg), 64'd11);
        b.query_rs2 = 5'd20; #1;
        chk("fl_pending20", 64'(b.issue_stall), 64'd1);

        // Reset with three entries queued
        rst = 1'b1;
        tick();
        chk("mr_reg_write", 64'(b.reg_write), 64'd0);
        chk("mr_count", 64'(b.wb_count), 64'd0);
        chk("mr_pending20", 64'(b.issue_stall), 64'd0);
        rst = 1'b0;
        tick();
        chk("mr_no_more_writes", 64'(b.reg_write), 64'd0);
        chk("mr_count_after", 64'(b.wb_count), 64'd0);
        b.query_rs2 = 5'd0;

        // Same-edge set/clear on f7
        b.issue_valid = 1'b1; b.issue_rd = 5'd7;
        tick();
        b.issue_valid = 1'b0; b.issue_rd = 5'd0;
        b.res0_valid = 1'b1; b.res0_rd = 5'd7; b.res0_data = 32'hC0A00000;
        tick();
        b.res0_valid = 1'b0;
        tick();
        chk("ss_commit7", 64'(b.write_reg), 64'd7);
        b.issue_valid = 1'b1; b.issue_rd = 5'd7; #1;
        chk("ss_stall_before", 64'(b.issue_stall), 64'd1);
        tick();
        b.issue_valid = 1'b0; b.issue_rd = 5'd0; b.query_rs3 = 5'd7; #1;
        chk("ss_pending7_kept", 64'(b.issue_stall), 64'd1);
        b.query_rs3 = 5'd0; b.issue_rd = 5'd7; #1;
        chk("ss_stall_via_rd", 64'(b.issue_stall), 64'd1);
        b.issue_rd = 5'd0;

        // DEPTH=2 instance: genuinely full, then one free slot
        b2.res0_valid = 1'b1; b2.res0_rd = 5'd3; b2.res0_data = 32'h11;
        b2.res1_valid = 1'b1; b2.res1_rd = 5'd4; b2.res1_data = 32'h22; #1;
        chk("d2_both_ready", 64'({b2.res0_ready, b2.res1_ready}), 64'b11);
        tick();
        chk("d2_full_count", 64'(b2.wb_count), 64'd2);
        chk("d2_full_res0_ready", 64'(b2.res0_ready), 64'd0);
        chk("d2_full_res1_ready", 64'(b2.res1_ready), 64'd0);
        tick();
        chk("d2_count1", 64'(b2.wb_count), 64'd1);
        chk("d2_pop3", 64'(b2.write_reg), 64'd3);
        chk("d2_free1_res0_ready", 64'(b2.res0_ready), 64'd1);
        chk("d2_free1_res1_ready", 64'(b2.res1_ready), 64'd0);
        b2.res0_valid = 1'b0; b2.res1_valid = 1'b0;
        tick();
        chk("d2_pop4_reg", 64'(b2.write_reg), 64'd4);
        chk("d2_pop4_data", 64'(b2.write_data), 64'h22);
        chk("d2_empty", 64'(b2.wb_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
